// File: rtl/trap_sequencer_if.sv
// Trap packet types and the pipeline/CSR-facing bundle of the trap sequencer.
package trap_pkg;
   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      TRAP_NONE   = 2'd0,
      TRAP_ENTER  = 2'd1,
      TRAP_RETURN = 2'd2
   } trap_mode_e;

   typedef struct packed {
      trap_mode_e      mode;
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] tval;
   } trap_pkt_t;
endpackage

interface trap_if;
   import trap_pkg::*;

   logic            exc_valid;
   logic [4:0]      exc_cause;
   logic [XLEN-1:0] exc_pc;
   logic [XLEN-1:0] exc_tval;
   logic            mret_valid;
   logic            irq_ext;
   logic            irq_sw;
   logic            irq_timer;
   logic            mstatus_mie;
   logic [XLEN-1:0] mie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] commit_pc;
   logic            pipe_empty;
   logic            stall_o;
   logic            flush_o;
   trap_pkt_t       trap_pkt;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            drain_timeout;

   modport master (
      output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
             irq_ext, irq_sw, irq_timer, mstatus_mie, mie, mtvec, mepc,
             commit_pc, pipe_empty,
      input  stall_o, flush_o, trap_pkt, redirect_valid, redirect_pc, drain_timeout
   );

   modport slave (
      input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid,
             irq_ext, irq_sw, irq_timer, mstatus_mie, mie, mtvec, mepc,
             commit_pc, pipe_empty,
      output stall_o, flush_o, trap_pkt, redirect_valid, redirect_pc, drain_timeout
   );
endinterface

// File: rtl/trap_sequencer.sv
// Arbitrates exceptions, MRET and machine interrupts, then sequences one trap:
// stall+flush, drain, one-cycle trap_pkt to the CSR unit, PC redirect.
module trap_sequencer #(
   parameter int DRAIN_MAX = 16,
   parameter int XLEN      = trap_pkg::XLEN
) (
   input logic   clk,
   input logic   rst,
   trap_if.slave bus
);
   import trap_pkg::*;

   localparam int CW = $clog2(DRAIN_MAX + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

   state_t          state_q, state_d;
   trap_pkt_t       lat_q, lat_d;
   logic [CW-1:0]   cnt_q;
   logic            stall_q, flush_q, rv_q, to_q;
   trap_pkt_t       pkt_q;
   logic            cnt_hit;
   logic            int_ext, int_sw, int_tmr;
   logic [XLEN-1:0] base, tgt;
   logic            unused_mie;

   assign int_ext = bus.mstatus_mie & bus.mie[11] & bus.irq_ext;
   assign int_sw  = bus.mstatus_mie & bus.mie[3]  & bus.irq_sw;
   assign int_tmr = bus.mstatus_mie & bus.mie[7]  & bus.irq_timer;
   assign cnt_hit = (cnt_q == CW'(DRAIN_MAX - 1));
   assign unused_mie = &{1'b0, bus.mie};

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      case (state_q)
         IDLE: begin
            if (bus.exc_valid) begin
               state_d = DRAIN;
               lat_d   = '{mode: TRAP_ENTER, cause: XLEN'(bus.exc_cause),
                           pc: bus.exc_pc, tval: bus.exc_tval};
            end else if (bus.mret_valid) begin
               state_d = DRAIN;
               lat_d   = '{mode: TRAP_RETURN, default: '0};
            end else if (int_ext | int_sw | int_tmr) begin
               state_d = DRAIN;
               lat_d   = '{mode: TRAP_ENTER, cause: '0, pc: bus.commit_pc, tval: '0};
               lat_d.cause[XLEN-1] = 1'b1;
               lat_d.cause[4:0]    = int_ext ? 5'd11 : (int_sw ? 5'd3 : 5'd7);
            end
         end
         DRAIN:    if (bus.pipe_empty || cnt_hit) state_d = COMMIT;
         COMMIT:   state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lat_q   <= '{mode: TRAP_NONE, default: '0};
         pkt_q   <= '{mode: TRAP_NONE, default: '0};
         cnt_q   <= '0;
         stall_q <= 1'b0;
         flush_q <= 1'b0;
         rv_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         cnt_q   <= (state_q == DRAIN) ? cnt_q + 1'b1 : '0;
         stall_q <= (state_d != IDLE);
         flush_q <= (state_q == IDLE) && (state_d == DRAIN);
         pkt_q   <= (state_d == COMMIT) ? lat_d : '{mode: TRAP_NONE, default: '0};
         rv_q    <= (state_d == REDIRECT);
         to_q    <= to_q | ((state_q == DRAIN) && !bus.pipe_empty && cnt_hit);
      end
   end

   // Target uses mtvec/mepc live in the REDIRECT cycle so the CSR write
   // triggered by trap_pkt in COMMIT is already visible.
   always_comb begin
      base = {bus.mtvec[XLEN-1:2], 2'b00};
      tgt  = base;
      if (lat_q.mode == TRAP_RETURN)
         tgt = bus.mepc;
      else if (bus.mtvec[1:0] == 2'b01 && lat_q.cause[XLEN-1])
         tgt = base + XLEN'({lat_q.cause[4:0], 2'b00});
      bus.redirect_pc = rv_q ? tgt : '0;
   end

   assign bus.stall_o        = stall_q;
   assign bus.flush_o        = flush_q;
   assign bus.trap_pkt       = pkt_q;
   assign bus.redirect_valid = rv_q;
   assign bus.drain_timeout  = to_q;
endmodule
